// File: rtl/dyt_lsu_mem_arbiter.sv
// Load/store arbiter: NUM_CH requestors share one SRAM port with lane
// formatting, load extension, misalignment errors and an ack timeout.
module dyt_lsu_mem_arbiter #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter bit          RR_EN   = 1'b1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_CH-1:0]        req_ren,
    input  logic [NUM_CH-1:0]        req_wen,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*32-1:0]     req_wdata,
    input  logic [NUM_CH*2-1:0]      req_type,
    input  logic [NUM_CH-1:0]        req_uns,
    output logic [NUM_CH-1:0]        req_gnt,
    output logic [NUM_CH-1:0]        req_err,
    output logic [31:0]              req_rdata,
    output logic                     sram_req,
    output logic                     sram_wen,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [31:0]              sram_wdata,
    output logic [3:0]               sram_ben,
    input  logic                     sram_ack,
    input  logic [31:0]              sram_rdata
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [CH_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_off;
    logic [1:0]         r_type;
    logic               r_uns;
    logic               r_wr;
    logic [NUM_CH-1:0]  r_gnt;
    logic [NUM_CH-1:0]  r_err;
    logic [31:0]        r_rdata;
    logic               r_sram_req;
    logic               r_sram_wen;
    logic [ADDR_W-1:0]  r_sram_addr;
    logic [31:0]        r_sram_wdata;
    logic [3:0]         r_sram_ben;

    logic [ADDR_W-1:0]  w_addr_a  [NUM_CH];
    logic [31:0]        w_wdata_a [NUM_CH];
    logic [1:0]         w_type_a  [NUM_CH];
    logic [NUM_CH-1:0]  w_cand;
    logic               w_any;
    logic [CH_W-1:0]    w_sel;
    int unsigned        w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_wdata;
    logic [1:0]         w_type;
    logic               w_ren;
    logic               w_wen;
    logic               w_bad;
    logic [31:0]        w_st_data;
    logic [3:0]         w_st_ben;
    logic [31:0]        w_shift;
    logic [31:0]        w_load;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_a[g] = req_wdata[g*32 +: 32];
        assign w_type_a[g]  = req_type[g*2 +: 2];
    end

    assign w_cand = req_ren | req_wen;

    // Pick the first requesting channel after the last grant (or lowest index)
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RR_EN)
                w_idx = (32'(r_ptr) + 32'd1 + 32'(i)) % NUM_CH;
            else
                w_idx = 32'(i);
            if (!w_any && w_cand[CH_W'(w_idx)]) begin
                w_any = 1'b1;
                w_sel = CH_W'(w_idx);
            end
        end
    end

    assign w_addr  = w_addr_a[w_sel];
    assign w_wdata = w_wdata_a[w_sel];
    assign w_type  = w_type_a[w_sel];
    assign w_ren   = req_ren[w_sel];
    assign w_wen   = req_wen[w_sel];

    always_comb begin
        w_bad = (w_type == 2'b11) || (w_ren && w_wen);
        if (w_type == 2'b01 && w_addr[0])
            w_bad = 1'b1;
        if (w_type == 2'b10 && w_addr[1:0] != 2'b00)
            w_bad = 1'b1;
    end

    // Replicate store data across lanes and pick the byte enables
    always_comb begin
        case (w_type)
            2'b00: begin
                w_st_data = {4{w_wdata[7:0]}};
                w_st_ben  = 4'b0001 << w_addr[1:0];
            end
            2'b01: begin
                w_st_data = {2{w_wdata[15:0]}};
                w_st_ben  = 4'b0011 << {w_addr[1], 1'b0};
            end
            default: begin
                w_st_data = w_wdata;
                w_st_ben  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_shift = sram_rdata >> {r_off, 3'b000};
        case (r_type)
            2'b00:   w_load = r_uns ? {24'h0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = r_uns ? {16'h0, w_shift[15:0]}
                                    : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_ptr        <= CH_W'(NUM_CH - 1);
            r_cnt        <= '0;
            r_off        <= '0;
            r_type       <= '0;
            r_uns        <= 1'b0;
            r_wr         <= 1'b0;
            r_gnt        <= '0;
            r_err        <= '0;
            r_rdata      <= '0;
            r_sram_req   <= 1'b0;
            r_sram_wen   <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_ben   <= '0;
        end else begin
            r_gnt      <= '0;
            r_err      <= '0;
            r_sram_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ch   <= w_sel;
                        r_ptr  <= w_sel;
                        r_off  <= w_addr[1:0];
                        r_type <= w_type;
                        r_uns  <= req_uns[w_sel];
                        r_wr   <= w_wen;
                        if (w_bad) begin
                            r_state <= S_DONE;
                            r_gnt   <= NUM_CH'(1) << w_sel;
                            r_err   <= NUM_CH'(1) << w_sel;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_sram_req   <= 1'b1;
                            r_sram_wen   <= w_wen;
                            r_sram_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
                            r_sram_wdata <= w_st_data;
                            r_sram_ben   <= w_st_ben;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    // Ack wins over a timeout in the same cycle
                    if (sram_ack) begin
                        r_state <= S_DONE;
                        r_gnt   <= NUM_CH'(1) << r_ch;
                        if (!r_wr)
                            r_rdata <= w_load;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state <= S_DONE;
                        r_gnt   <= NUM_CH'(1) << r_ch;
                        r_err   <= NUM_CH'(1) << r_ch;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_gnt    = r_gnt;
    assign req_err    = r_err;
    assign req_rdata  = r_rdata;
    assign sram_req   = r_sram_req;
    assign sram_wen   = r_sram_wen;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign sram_ben   = r_sram_ben;

endmodule

// File: tb/tb_dyt_lsu_mem_arbiter.sv
// Bench for dyt_lsu_mem_arbiter: vector table plus scoreboard, reset abort
// and arbitration order sequences on a round-robin and a fixed-priority copy.
module tb_dyt_lsu_mem_arbiter;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned TO  = 8;

    typedef struct {
        int         ch;
        bit         ren;
        bit         wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0] typ;
        bit         uns;
        int         ack_cyc;
        logic [31:0] srd;
        bit         x_req;
        bit         x_wen;
        logic [31:0] x_saddr;
        logic [31:0] x_swd;
        logic [3:0] x_ben;
        bit         x_err;
        int         x_gcyc;
        bit         x_rd;
        logic [31:0] x_rdata;
    } vec_t;

    typedef struct {
        logic [NCH-1:0] gnt;
        logic [NCH-1:0] err;
        logic [31:0]    rdata;
    } sb_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      req_ren, req_wen, req_uns;
    logic [NCH*AW-1:0]   req_addr;
    logic [NCH*32-1:0]   req_wdata;
    logic [NCH*2-1:0]    req_type;
    logic [31:0]         sram_rdata;
    logic                man_ack, auto_ack;

    logic [NCH-1:0] rr_gnt, rr_err, fp_gnt, fp_err;
    logic [31:0]    rr_rdata, fp_rdata, rr_swd, fp_swd;
    logic [AW-1:0]  rr_saddr, fp_saddr;
    logic [3:0]     rr_sben, fp_sben;
    logic           rr_sreq, fp_sreq, rr_swen, fp_swen;
    logic           rr_req_d, fp_req_d, rr_ack, fp_ack;

    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 1'b0;
    sb_t  sbq[$];
    logic [31:0] m_rdata = 32'h0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    dyt_lsu_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .RR_EN(1'b1), .TIMEOUT(TO)) u_rr (
        .CLK(clk), .nRST(rst_n),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_type(req_type), .req_uns(req_uns),
        .req_gnt(rr_gnt), .req_err(rr_err), .req_rdata(rr_rdata),
        .sram_req(rr_sreq), .sram_wen(rr_swen), .sram_addr(rr_saddr),
        .sram_wdata(rr_swd), .sram_ben(rr_sben),
        .sram_ack(rr_ack), .sram_rdata(sram_rdata)
    );

    dyt_lsu_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .RR_EN(1'b0), .TIMEOUT(TO)) u_fp (
        .CLK(clk), .nRST(rst_n),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_type(req_type), .req_uns(req_uns),
        .req_gnt(fp_gnt), .req_err(fp_err), .req_rdata(fp_rdata),
        .sram_req(fp_sreq), .sram_wen(fp_swen), .sram_addr(fp_saddr),
        .sram_wdata(fp_swd), .sram_ben(fp_sben),
        .sram_ack(fp_ack), .sram_rdata(sram_rdata)
    );

    // SRAM model that acks the cycle after each strobe when auto_ack is set
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_req_d <= 1'b0;
            fp_req_d <= 1'b0;
        end else begin
            rr_req_d <= rr_sreq;
            fp_req_d <= fp_sreq;
        end
    end
    assign rr_ack = man_ack | (auto_ack & rr_req_d);
    assign fp_ack = man_ack | (auto_ack & fp_req_d);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_on && rst_n && rr_gnt != '0) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_gnt", 32'(rr_gnt), 32'h0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_gnt", 32'(rr_gnt), 32'(e.gnt));
                chk("sb_err", 32'(rr_err), 32'(e.err));
                chk("sb_rdata", rr_rdata, e.rdata);
            end
        end
    end

    task automatic clear_req();
        req_ren = '0; req_wen = '0; req_uns = '0;
        req_addr = '0; req_wdata = '0; req_type = '0;
    endtask

    task automatic drive(input int ch, input bit ren, input bit wen, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] typ, input bit uns);
        req_ren[ch] = ren;
        req_wen[ch] = wen;
        req_uns[ch] = uns;
        req_addr[ch*AW +: AW]  = addr;
        req_wdata[ch*32 +: 32] = wd;
        req_type[ch*2 +: 2]    = typ;
    endtask

    // Called at the negedge of an IDLE cycle, which becomes cycle 0
    task automatic run_vec(input vec_t v, input int idx);
        sb_t e;
        int  gc;
        clear_req();
        drive(v.ch, v.ren, v.wen, v.addr, v.wdata, v.typ, v.uns);
        e.gnt   = NCH'(1) << v.ch;
        e.err   = v.x_err ? e.gnt : '0;
        e.rdata = v.x_rd ? v.x_rdata : m_rdata;
        m_rdata = e.rdata;
        sbq.push_back(e);
        gc = 0;
        for (int c = 1; c <= 40 && gc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk($sformatf("v%0d_sram_req", idx), 32'(rr_sreq), 32'(v.x_req));
                if (v.x_req) begin
                    chk($sformatf("v%0d_sram_addr", idx), rr_saddr, v.x_saddr);
                    chk($sformatf("v%0d_sram_ben", idx), 32'(rr_sben), 32'(v.x_ben));
                    chk($sformatf("v%0d_sram_wen", idx), 32'(rr_swen), 32'(v.x_wen));
                    if (v.x_wen)
                        chk($sformatf("v%0d_sram_wdata", idx), rr_swd, v.x_swd);
                end
            end
            if (c == 2 && v.x_req)
                chk($sformatf("v%0d_sram_req_pulse", idx), 32'(rr_sreq), 32'h0);
            man_ack    = (c == v.ack_cyc);
            sram_rdata = (c == v.ack_cyc) ? v.srd : 32'h0;
            if (rr_gnt != '0)
                gc = c;
        end
        chk($sformatf("v%0d_gnt_cycle", idx), 32'(gc), 32'(v.x_gcyc));
        man_ack = 1'b0;
        clear_req();
        @(negedge clk);
    endtask

    initial begin
        int rr_ord[4], fp_ord[4], rr_cyc[4];
        int nrr, nfp;

        vecs[0]  = '{1,1,0,32'h100,32'h0,2'b10,0, 2,32'hDEADBEEF, 1,0,32'h100,32'h0,4'hF, 0,3,1,32'hDEADBEEF};
        vecs[1]  = '{0,1,0,32'h103,32'h0,2'b00,0, 2,32'h80123456, 1,0,32'h100,32'h0,4'h8, 0,3,1,32'hFFFFFF80};
        vecs[2]  = '{1,1,0,32'h103,32'h0,2'b00,1, 2,32'h80123456, 1,0,32'h100,32'h0,4'h8, 0,3,1,32'h00000080};
        vecs[3]  = '{0,0,1,32'h102,32'h1234ABCD,2'b01,0, 2,32'h0, 1,1,32'h100,32'hABCDABCD,4'hC, 0,3,0,32'h0};
        vecs[4]  = '{0,1,0,32'h101,32'h0,2'b10,0, 0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,1,0,32'h0};
        vecs[5]  = '{1,1,0,32'h200,32'h0,2'b10,0, 0,32'h0, 1,0,32'h200,32'h0,4'hF, 1,10,0,32'h0};
        vecs[6]  = '{0,1,0,32'h102,32'h0,2'b01,0, 4,32'h80011234, 1,0,32'h100,32'h0,4'hC, 0,5,1,32'hFFFF8001};
        vecs[7]  = '{1,0,1,32'h201,32'h000000A5,2'b00,0, 2,32'h0, 1,1,32'h200,32'hA5A5A5A5,4'h2, 0,3,0,32'h0};
        vecs[8]  = '{0,1,0,32'h100,32'h0,2'b11,0, 0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,1,0,32'h0};
        vecs[9]  = '{1,1,1,32'h100,32'h5,2'b10,0, 0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,1,0,32'h0};
        vecs[10] = '{0,1,0,32'h101,32'h0,2'b01,1, 0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,1,0,32'h0};
        vecs[11] = '{1,1,0,32'h100,32'h0,2'b01,1, 2,32'h1234F00D, 1,0,32'h100,32'h0,4'h3, 0,3,1,32'h0000F00D};
        vecs[12] = '{0,1,0,32'h300,32'h0,2'b10,0, 9,32'h0BADCAFE, 1,0,32'h300,32'h0,4'hF, 0,10,1,32'h0BADCAFE};
        vecs[13] = '{1,1,0,32'h101,32'h0,2'b00,0, 2,32'h00007F00, 1,0,32'h100,32'h0,4'h2, 0,3,1,32'h0000007F};

        rst_n = 1'b0;
        man_ack = 1'b0;
        auto_ack = 1'b0;
        sram_rdata = 32'h0;
        clear_req();
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(rr_gnt), 32'h0);
        chk("rst_sram_req", 32'(rr_sreq), 32'h0);
        chk("rst_rdata", rr_rdata, 32'h0);
        chk("rst_sram_addr", rr_saddr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        sb_on = 1'b1;

        for (int i = 0; i < 14; i++)
            run_vec(vecs[i], i);

        // Asynchronous reset in the middle of WAIT aborts the access
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(rr_gnt), 32'h0);
        chk("abort_err", 32'(rr_err), 32'h0);
        chk("abort_rdata", rr_rdata, 32'h0);
        chk("abort_sram_req", 32'(rr_sreq), 32'h0);
        chk("abort_sram_wen", 32'(rr_swen), 32'h0);
        chk("abort_sram_addr", rr_saddr, 32'h0);
        chk("abort_sram_wdata", rr_swd, 32'h0);
        chk("abort_sram_ben", 32'(rr_sben), 32'h0);
        m_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        man_ack = 1'b1;
        sram_rdata = 32'h11111111;
        @(negedge clk);
        man_ack = 1'b0;
        sram_rdata = 32'h0;
        chk("restart_sram_req", 32'(rr_sreq), 32'h1);
        chk("restart_no_gnt", 32'(rr_gnt), 32'h0);
        sbq.push_back('{2'b01, 2'b00, 32'hCAFEF00D});
        m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        man_ack = 1'b1;
        sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        man_ack = 1'b0;
        chk("restart_gnt", 32'(rr_gnt), 32'h1);
        clear_req();
        @(negedge clk);

        // Two continuous requestors with immediate ack, starting from reset
        sb_on = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        auto_ack = 1'b1;
        sram_rdata = 32'h55AA55AA;
        drive(0, 1'b1, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h004, 32'h0, 2'b10, 1'b0);
        nrr = 0;
        nfp = 0;
        for (int c = 1; c <= 40 && (nrr < 4 || nfp < 4); c++) begin
            @(negedge clk);
            if (rr_gnt != '0 && nrr < 4) begin
                rr_ord[nrr] = (rr_gnt == 2'b01) ? 0 : (rr_gnt == 2'b10) ? 1 : 9;
                rr_cyc[nrr] = c;
                chk($sformatf("arb_rr_err%0d", nrr), 32'(rr_err), 32'h0);
                nrr++;
            end
            if (fp_gnt != '0 && nfp < 4) begin
                fp_ord[nfp] = (fp_gnt == 2'b01) ? 0 : (fp_gnt == 2'b10) ? 1 : 9;
                nfp++;
            end
        end
        chk("arb_rr_count", 32'(nrr), 32'd4);
        chk("arb_fp_count", 32'(nfp), 32'd4);
        for (int k = 0; k < nrr; k++) begin
            chk($sformatf("arb_rr_order%0d", k), 32'(rr_ord[k]), 32'(k % 2));
            chk($sformatf("arb_rr_cycle%0d", k), 32'(rr_cyc[k]), 32'(3 + 4 * k));
        end
        for (int k = 0; k < nfp; k++)
            chk($sformatf("arb_fp_order%0d", k), 32'(fp_ord[k]), 32'h0);
        clear_req();
        auto_ack = 1'b0;
        repeat (6) @(negedge clk);

        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dyt_lsu_mem_arbiter.md
# dyt_lsu_mem_arbiter

Parametrised load/store memory arbiter between NUM_CH CPU-side requestors (instruction fetch, data, debug, …) and a single SRAM port. It adds several things to the two-port LSU handshake: round-robin or fixed-priority arbitration, byte/half/word write lane strobes, load alignment with sign/zero extension, misalignment detection, and an SRAM acknowledge timeout. Sits between the CPU datapath and the dyt_sram port.

## Interface
- NUM_CH, 2: number of requestor channels, 1..8.
- ADDR_W, 32: address width; data width is fixed at 32.
- RR_EN, 1: 1 = round-robin arbitration, 0 = fixed priority with ch0 highest.
- TIMEOUT, 16: maximum WAIT cycles without sram_ack, ≥2.
- CLK  in  1  clock, rising edge.
- nRST  in  1  one clock; reset is asynchronous and active-low.
- req_ren  in  NUM_CH  per-channel read request, level, held until gnt.
- req_wen  in  NUM_CH  per-channel write request, level, held until gnt.
- req_addr  in  NUM_CH*ADDR_W  per-channel byte address, ch i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*32  per-channel store data, right-aligned.
- req_type  in  NUM_CH*2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_uns  in  NUM_CH  1 = zero-extend loads, 0 = sign-extend.
- req_gnt  out  NUM_CH  one-cycle completion pulse, one-hot or zero.
- req_err  out  NUM_CH  error flag, valid only with gnt.
- req_rdata  out  32  aligned and extended load data, valid in the gnt cycle.
- sram_req  out  1  one-cycle access strobe.
- sram_wen  out  1  1 = write, 0 = read; qualified by sram_req.
- sram_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00).
- sram_wdata  out  32  lane-replicated store data.
- sram_ben  out  4  byte-lane enables.
- sram_ack  in  1  completion; sram_rdata is valid in the same cycle.
- sram_rdata  in  32  raw word read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Candidate channels have req_ren or req_wen set; pick one by arbitration.
  - Latch channel, addr, wdata, type, uns and op (write if wen).
  - Next state is ISSUE, or DONE with err (no SRAM access) if any of:
    - type = 11;
    - half with addr[0] = 1;
    - word with addr[1:0] ≠ 0;
    - ren and wen both set.
- **ISSUE**: sram_req = 1 for exactly one cycle with the latched fields, then WAIT.
- **WAIT**
  - Cycle counter counts from 0.
  - sram_ack → DONE: capture the load result for reads, err = 0.
  - Counter reaches TIMEOUT-1 with no ack → DONE with err = 1.
- **DONE**: req_gnt[ch] = 1, req_err[ch] = err for one cycle, then IDLE.
- Arbitration
  - Round-robin: pointer = last granted channel; search starts at pointer+1 mod NUM_CH. Pointer resets to NUM_CH-1, so ch0 wins first.
  - Pointer updates on every grant, including error grants.
  - RR_EN = 0: lowest index wins.
- Store formatting
  - byte: wdata[7:0] replicated ×4; ben = 0001 << addr[1:0].
  - half: wdata[15:0] replicated ×2; ben = 0011 << (2*addr[1]).
  - word: ben = 1111.
  - Reads drive the same ben.
- Load formatting
  - Shift sram_rdata right by 8*addr[1:0].
  - Byte/half: extend bit 7/15 (sign) or zero per uns.
- req_rdata holds its previous value on write and error grants.
- sram_ack outside WAIT is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; rr pointer NUM_CH-1; counter 0.
- nRST asserted mid-transaction aborts immediately: no gnt is issued, the requestor keeps requesting, and a late ack is ignored.
- Cycle numbering for an aligned access:
  - Request visible in cycle 0 (IDLE).
  - sram_req in cycle 1.
  - Earliest ack in cycle 2.
  - gnt in cycle ack+1, so minimum latency is 3 cycles.
- Error path latency: misaligned or illegal request in cycle 0 gives gnt+err in cycle 1.
- Timeout latency: no ack produces gnt+err in cycle 2+TIMEOUT.
- Requestors may change or drop their request in the cycle after gnt; IDLE sees the updated inputs.
- Back-to-back throughput: one access per 4 cycles with immediate ack.
- A request withdrawn before gnt is a protocol violation; the latched transaction completes regardless.

## Test plan
- **Reset**: drive nRST = 0 asynchronously mid-WAIT → all outputs 0 in the same cycle; after release, an ack is ignored and the held request restarts from IDLE.
- **Word read**: ch1 reads 0x100, ack in cycle 2 with sram_rdata 0xDEADBEEF → sram_addr 0x100, ben 1111 in cycle 1; gnt[1] and rdata 0xDEADBEEF in cycle 3; err 0.
- **Byte load**: 0x103 with sram_rdata 0x80123456 → rdata 0xFFFFFF80 with uns = 0, 0x00000080 with uns = 1.
- **Half store**: 0x102 with wdata 0x1234ABCD → sram_wen 1, sram_wdata 0xABCDABCD, ben 1100, sram_addr 0x100.
- **Arbitration**: ch0 and ch1 request continuously with immediate ack → grant order 0,1,0,1 for RR_EN = 1 and 0,0,0,0 for RR_EN = 0.
- **Errors**:
  - Word at 0x101 → gnt+err in cycle 1, no sram_req.
  - TIMEOUT = 8, no ack → gnt+err in cycle 10, rdata unchanged.
